// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged
// -----------------
// Single-clock FIFO for same-clock producer/consumer paths. The depth can be
// any integer of 2 or more, so pointers wrap with an explicit compare instead
// of relying on power-of-two rollover. Status flags are decoded from the
// registered occupancy count, so they never glitch on input changes. The
// error flags are sticky. The read port works either as a registered read or
// as first-word-fall-through.
//
// Parameters
//   DEPTH      number of entries (>= 2)
//   WIDTH      data word width
//   AF_THRESH  almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   w_en, r_en    write / read requests
//   clr_err       pulse that clears overflow and underflow
//   data_in       write data
//   data_out      read data
//   full, empty, almost_full, almost_empty   occupancy flags
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
module sync_fifo_flagged #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL  = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LEVEL  = CW'(AE_THRESH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    // Reject configurations that would give meaningless flags or pointers.
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_flagged: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_flagged: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_flagged: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic is_full, is_empty;
    logic r_acc, w_acc;

    assign is_full  = (count_q == COUNT_MAX);
    assign is_empty = (count_q == '0);

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle; a read from an empty FIFO is never accepted.
    assign r_acc = r_en && !is_empty;
    assign w_acc = w_en && (!is_full || r_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (w_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (r_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        if (w_acc && !r_acc) begin
            count_d = count_q + 1'b1;
        end else if (r_acc && !w_acc) begin
            count_d = count_q - 1'b1;
        end

        // Clear first so that an error in the same cycle overrides it.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && !w_acc) begin
            overflow_d = 1'b1;
        end
        if (r_en && !r_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; the count tracks validity.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; zero when nothing is stored.
        assign data_out = is_empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
        logic [WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (r_acc) begin
                dout_d = mem[rd_ptr_q];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= AF_LEVEL);
    assign almost_empty = (count_q <= AE_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Testbench for sync_fifo_flagged. Three instances share clock and reset:
//   u6  : DEPTH=6,  AF=5,  AE=1, standard read
//   u16 : DEPTH=16, AF=12, AE=4, standard read
//   uf  : DEPTH=4,  AF=3,  AE=1, first-word-fall-through
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_sync_fifo_flagged;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   int testsRun    = 0;
   int testsFailed = 0;

   // u6 signals
   logic       w6, r6, c6;
   logic [7:0] d6, q6;
   logic       full6, empty6, af6, ae6, ov6, un6;
   logic [2:0] cnt6;

   // u16 signals
   logic       w16, r16, c16;
   logic [7:0] d16, q16;
   logic       full16, empty16, af16, ae16, ov16, un16;
   logic [4:0] cnt16;

   // uf signals
   logic       wf, rf, cf;
   logic [7:0] df, qf;
   logic       fullf, emptyf, aff, aef, ovf, unf;
   logic [2:0] cntf;

   sync_fifo_flagged #(.DEPTH(6), .WIDTH(8), .AF_THRESH(5), .AE_THRESH(1), .FWFT(0)) u6 (
      .clk(clock), .rst(reset), .w_en(w6), .r_en(r6), .clr_err(c6), .data_in(d6),
      .data_out(q6), .full(full6), .empty(empty6), .almost_full(af6),
      .almost_empty(ae6), .count(cnt6), .overflow(ov6), .underflow(un6)
   );

   sync_fifo_flagged #(.DEPTH(16), .WIDTH(8), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u16 (
      .clk(clock), .rst(reset), .w_en(w16), .r_en(r16), .clr_err(c16), .data_in(d16),
      .data_out(q16), .full(full16), .empty(empty16), .almost_full(af16),
      .almost_empty(ae16), .count(cnt16), .overflow(ov16), .underflow(un16)
   );

   sync_fifo_flagged #(.DEPTH(4), .WIDTH(8), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) uf (
      .clk(clock), .rst(reset), .w_en(wf), .r_en(rf), .clr_err(cf), .data_in(df),
      .data_out(qf), .full(fullf), .empty(emptyf), .almost_full(aff),
      .almost_empty(aef), .count(cntf), .overflow(ovf), .underflow(unf)
   );

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reset values, then an asynchronous reset in the middle of a fill.
   task automatic test_reset();
      logic [12:0] got;
      logic [12:0] exp;
      reset = 1'b1;
      #12;
      got = {cnt6, empty6, ae6, full6, af6, ov6, un6, 1'b0, 4'h0};
      exp = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags6: got %b expected %b", got, exp);
      end
      testsRun++;
      if (q6 !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset_dout6: got %h expected 00", q6);
      end
      testsRun++;
      if ({cnt16, empty16, ae16, full16, qf, emptyf} !== {5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL reset_others: cnt16=%0d e16=%b ae16=%b f16=%b qf=%h ef=%b expected 0 1 1 0 00 1",
                  cnt16, empty16, ae16, full16, qf, emptyf);
      end
      #10 reset = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         w6 = 1'b1;
         d6 = 8'(8'h70 + i);
         tick();
      end
      w6 = 1'b0;
      testsRun++;
      if (cnt6 !== 3'd5) begin
         testsFailed++;
         $display("[TB] FAIL midfill_count: got %0d expected 5", cnt6);
      end
      #2 reset = 1'b1;
      #1;
      testsRun++;
      if ({cnt6, empty6, ae6, full6, ov6, un6} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL midfill_async_reset: cnt=%0d e=%b ae=%b f=%b ov=%b un=%b expected 0 1 1 0 0 0",
                  cnt6, empty6, ae6, full6, ov6, un6);
      end
      #3 reset = 1'b0;
      tick();
   endtask

   // Fill and drain DEPTH=6, then again with pointers offset to force a wrap.
   task automatic test_fill_drain();
      logic [7:0] base;
      for (int pass = 0; pass < 2; pass++) begin
         base = (pass == 0) ? 8'h11 : 8'h41;
         if (pass == 1) begin
            for (int i = 0; i < 3; i++) begin
               w6 = 1'b1;
               d6 = 8'(8'h31 + i);
               tick();
            end
            w6 = 1'b0;
            for (int i = 0; i < 3; i++) begin
               r6 = 1'b1;
               tick();
               testsRun++;
               if (q6 !== 8'(8'h31 + i)) begin
                  testsFailed++;
                  $display("[TB] FAIL offset_read%0d: got %h expected %h", i, q6, 8'(8'h31 + i));
               end
            end
            r6 = 1'b0;
         end
         for (int i = 0; i < 6; i++) begin
            w6 = 1'b1;
            d6 = 8'(base + i);
            tick();
            testsRun++;
            if ({cnt6, full6} !== {3'(i + 1), (i == 5)}) begin
               testsFailed++;
               $display("[TB] FAIL fill%0d_w%0d: cnt=%0d full=%b expected cnt=%0d full=%b",
                        pass, i, cnt6, full6, i + 1, (i == 5));
            end
         end
         w6 = 1'b0;
         testsRun++;
         if (af6 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fill%0d_almost_full: got %b expected 1", pass, af6);
         end
         for (int i = 0; i < 6; i++) begin
            r6 = 1'b1;
            tick();
            testsRun++;
            if (q6 !== 8'(base + i)) begin
               testsFailed++;
               $display("[TB] FAIL drain%0d_r%0d: got %h expected %h", pass, i, q6, 8'(base + i));
            end
         end
         r6 = 1'b0;
         testsRun++;
         if ({empty6, cnt6} !== {1'b1, 3'd0}) begin
            testsFailed++;
            $display("[TB] FAIL drain%0d_empty: empty=%b cnt=%0d expected 1 0", pass, empty6, cnt6);
         end
      end
   endtask

   // Rejected write at full, error clear, and clear colliding with a new error.
   task automatic test_overflow();
      for (int i = 0; i < 6; i++) begin
         w6 = 1'b1;
         d6 = 8'(8'h61 + i);
         tick();
      end
      w6 = 1'b1;
      d6 = 8'hAA;
      tick();
      w6 = 1'b0;
      testsRun++;
      if ({ov6, cnt6, un6} !== {1'b1, 3'd6, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL overflow_set: ov=%b cnt=%0d un=%b expected 1 6 0", ov6, cnt6, un6);
      end
      c6 = 1'b1;
      tick();
      c6 = 1'b0;
      testsRun++;
      if (ov6 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL overflow_clear: got %b expected 0", ov6);
      end
      w6 = 1'b1;
      c6 = 1'b1;
      d6 = 8'hAA;
      tick();
      w6 = 1'b0;
      c6 = 1'b0;
      testsRun++;
      if (ov6 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL overflow_set_wins: got %b expected 1", ov6);
      end
      c6 = 1'b1;
      tick();
      c6 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         r6 = 1'b1;
         tick();
         testsRun++;
         if (q6 !== 8'(8'h61 + i)) begin
            testsFailed++;
            $display("[TB] FAIL overflow_drain%0d: got %h expected %h", i, q6, 8'(8'h61 + i));
         end
      end
      r6 = 1'b0;
   endtask

   // Rejected read at empty; simultaneous read/write on empty.
   task automatic test_underflow();
      r6 = 1'b1;
      tick();
      r6 = 1'b0;
      testsRun++;
      if ({un6, q6, cnt6} !== {1'b1, 8'h66, 3'd0}) begin
         testsFailed++;
         $display("[TB] FAIL underflow_set: un=%b dout=%h cnt=%0d expected 1 66 0", un6, q6, cnt6);
      end
      c6 = 1'b1;
      tick();
      c6 = 1'b0;
      testsRun++;
      if (un6 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL underflow_clear: got %b expected 0", un6);
      end
      r6 = 1'b1;
      w6 = 1'b1;
      d6 = 8'h5C;
      tick();
      r6 = 1'b0;
      w6 = 1'b0;
      testsRun++;
      if ({cnt6, un6, ov6, q6} !== {3'd1, 1'b1, 1'b0, 8'h66}) begin
         testsFailed++;
         $display("[TB] FAIL rw_on_empty: cnt=%0d un=%b ov=%b dout=%h expected 1 1 0 66",
                  cnt6, un6, ov6, q6);
      end
      r6 = 1'b1;
      tick();
      r6 = 1'b0;
      testsRun++;
      if ({q6, empty6} !== {8'h5C, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL rw_on_empty_read: dout=%h empty=%b expected 5c 1", q6, empty6);
      end
   endtask

   // Simultaneous read and write at full, DEPTH=16.
   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         w16 = 1'b1;
         d16 = 8'(i);
         tick();
      end
      w16 = 1'b0;
      testsRun++;
      if ({full16, cnt16, af16} !== {1'b1, 5'd16, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL b2b_fill: full=%b cnt=%0d af=%b expected 1 16 1", full16, cnt16, af16);
      end
      for (int i = 0; i < 20; i++) begin
         w16 = 1'b1;
         r16 = 1'b1;
         d16 = 8'(16 + i);
         tick();
         testsRun++;
         if ({q16, cnt16, full16, ov16} !== {8'(i), 5'd16, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL b2b_cycle%0d: dout=%h cnt=%0d full=%b ov=%b expected %h 16 1 0",
                     i, q16, cnt16, full16, ov16, 8'(i));
         end
      end
      w16 = 1'b0;
      r16 = 1'b0;
   endtask

   // First-word-fall-through: visibility, thresholds, and drain to zero.
   task automatic test_fwft();
      wf = 1'b1;
      df = 8'h01;
      tick();
      wf = 1'b0;
      testsRun++;
      if ({emptyf, qf, aef, cntf} !== {1'b0, 8'h01, 1'b1, 3'd1}) begin
         testsFailed++;
         $display("[TB] FAIL fwft_first_word: empty=%b dout=%h ae=%b cnt=%0d expected 0 01 1 1",
                  emptyf, qf, aef, cntf);
      end
      wf = 1'b1;
      df = 8'h02;
      tick();
      testsRun++;
      if ({aef, aff, cntf} !== {1'b0, 1'b0, 3'd2}) begin
         testsFailed++;
         $display("[TB] FAIL fwft_count2: ae=%b af=%b cnt=%0d expected 0 0 2", aef, aff, cntf);
      end
      df = 8'h03;
      tick();
      wf = 1'b0;
      testsRun++;
      if ({aff, cntf, qf} !== {1'b1, 3'd3, 8'h01}) begin
         testsFailed++;
         $display("[TB] FAIL fwft_count3: af=%b cnt=%0d dout=%h expected 1 3 01", aff, cntf, qf);
      end
      for (int i = 0; i < 3; i++) begin
         rf = 1'b1;
         tick();
         testsRun++;
         if ({qf, emptyf} !== {((i == 2) ? 8'h00 : 8'(8'h02 + i)), (i == 2)}) begin
            testsFailed++;
            $display("[TB] FAIL fwft_pop%0d: dout=%h empty=%b expected %h %b",
                     i, qf, emptyf, ((i == 2) ? 8'h00 : 8'(8'h02 + i)), (i == 2));
         end
      end
      rf = 1'b0;
   endtask

   // Test sequence
   initial begin
      {w6, r6, c6, w16, r16, c16, wf, rf, cf} = '0;
      d6  = 8'h00;
      d16 = 8'h00;
      df  = 8'h00;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_fwft();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
